// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: PC width, branch-select encodings and fetch FSM states.
package cpu_pkg;
  localparam int PC_W = 16;

  localparam logic [1:0] BR_BL     = 2'b00;
  localparam logic [1:0] BR_COND   = 2'b01;
  localparam logic [1:0] BR_UNCOND = 2'b10;
  localparam logic [1:0] BR_SEQ    = 2'b11;

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HAVE = 2'd2;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory channel: valid/ready request plus in-order, variable-latency response.
interface fetch_unit_if;
  import cpu_pkg::*;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [15:0]     imem_rsp_data;

  modport master (output imem_req_valid, imem_req_addr,
                  input  imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave  (input  imem_req_valid, imem_req_addr,
                  output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/br_target_calc.sv
// Combinational branch decision, PC-relative target and BL link address.
module br_target_calc
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_BIAS = 16'd2
) (
  input  logic            redirect_valid,
  input  logic [1:0]      brSel,
  input  logic            brEx,
  input  logic [PC_W-1:0] br_pc,
  input  logic [15:0]     br_instr,
  input  logic [PC_W-1:0] brx_target,
  output logic            taken,
  output logic [PC_W-1:0] target,
  output logic [PC_W-1:0] link_addr
);
  logic [PC_W-1:0] base;
  logic            unused_instr_hi;

  assign base            = br_pc + PC_BIAS;
  assign link_addr       = br_pc + 16'd1;
  assign taken           = redirect_valid & (brEx | (brSel != BR_SEQ));
  assign unused_instr_hi = ^br_instr[15:11];

  // BX overrides brSel; all sums wrap modulo 2^16.
  always_comb begin
    target = base;
    if (brEx) begin
      target = brx_target;
    end else begin
      case (brSel)
        BR_COND:   target = base + {{8{br_instr[7]}}, br_instr[7:0]};
        BR_UNCOND: target = base + {{5{br_instr[10]}}, br_instr[10:0]};
        BR_BL:     target = base + {{10{br_instr[5]}}, br_instr[5:0]};
        default:   target = base;
      endcase
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches one halfword at a time and hands PC/instr to decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [PC_W-1:0] PC_BIAS  = 16'd2
) (
  input  logic            clk,
  input  logic            reset,
  fetch_unit_if.master    imem,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [PC_W-1:0] PC,
  output logic [15:0]     instr,
  input  logic            redirect_valid,
  input  logic [1:0]      brSel,
  input  logic            brEx,
  input  logic [PC_W-1:0] br_pc,
  input  logic [15:0]     br_instr,
  input  logic [PC_W-1:0] brx_target,
  output logic [PC_W-1:0] link_addr,
  output logic [1:0]      state_dbg
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // a valid source holds its payload stable until that edge (redirect may replace the request).
  logic [1:0]      state;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] req_pc;
  logic            drop;
  logic            started;
  logic            taken;
  logic [PC_W-1:0] target;
  logic            req_fire;

  br_target_calc #(.PC_BIAS(PC_BIAS)) u_br (
    .redirect_valid (redirect_valid),
    .brSel          (brSel),
    .brEx           (brEx),
    .br_pc          (br_pc),
    .br_instr       (br_instr),
    .brx_target     (brx_target),
    .taken          (taken),
    .target         (target),
    .link_addr      (link_addr)
  );

  // started keeps the request low until the first edge after reset release.
  assign imem.imem_req_valid = started && (state == ST_REQ);
  assign imem.imem_req_addr  = fetch_pc;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;
  assign instr_valid         = (state == ST_HAVE);
  assign state_dbg           = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      drop     <= 1'b0;
      started  <= 1'b0;
      PC       <= '0;
      instr    <= '0;
    end else begin
      started <= 1'b1;
      if (taken) begin
        fetch_pc <= target;
        case (state)
          ST_REQ: begin
            // An accepted request still owes a response, which must be squashed.
            if (req_fire) begin
              req_pc <= fetch_pc;
              drop   <= 1'b1;
              state  <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem.imem_rsp_valid) begin
              drop  <= 1'b0;
              state <= ST_REQ;
            end else begin
              drop  <= 1'b1;
            end
          end
          default: state <= ST_REQ;
        endcase
      end else begin
        case (state)
          ST_REQ: begin
            if (req_fire) begin
              req_pc <= fetch_pc;
              state  <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem.imem_rsp_valid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= ST_REQ;
              end else begin
                PC    <= req_pc;
                instr <= imem.imem_rsp_data;
                state <= ST_HAVE;
              end
            end
          end
          ST_HAVE: begin
            if (instr_ready) begin
              fetch_pc <= PC + 16'd1;
              state    <= ST_REQ;
            end
          end
          default: state <= ST_REQ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-outstanding, configurable-latency memory model.
module tb_fetch_unit;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        instr_ready, redirect_valid, brEx;
  logic [1:0]  brSel;
  logic [15:0] br_pc, br_instr, brx_target;
  logic        instr_valid;
  logic [15:0] PC, instr, link_addr;
  logic [1:0]  state_dbg;

  fetch_unit_if imem();

  fetch_unit #(.RESET_PC(16'h0000), .PC_BIAS(16'd2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (imem),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .PC             (PC),
    .instr          (instr),
    .redirect_valid (redirect_valid),
    .brSel          (brSel),
    .brEx           (brEx),
    .br_pc          (br_pc),
    .br_instr       (br_instr),
    .brx_target     (brx_target),
    .link_addr      (link_addr),
    .state_dbg      (state_dbg)
  );

  // ---------------- memory model + scoreboard logs ----------------
  logic        mem_ready = 1'b1;
  int          mem_lat = 1;
  logic        pend = 1'b0;
  logic [15:0] pend_addr = '0;
  int          pend_cnt = 0;
  logic [15:0] req_log[$];
  logic [31:0] pres_log[$];
  int          n_checks = 0;
  int          n_pass = 0;

  assign imem.imem_req_ready = mem_ready;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      pend = 1'b0;
    end else begin
      if (imem.imem_rsp_valid) pend = 1'b0;
      if (imem.imem_req_valid && imem.imem_req_ready) begin
        pend      = 1'b1;
        pend_addr = imem.imem_req_addr;
        pend_cnt  = mem_lat;
        req_log.push_back(imem.imem_req_addr);
      end
      if (instr_valid && instr_ready && !redirect_valid) pres_log.push_back({PC, instr});
    end
  end

  always @(negedge clk) begin
    imem.imem_rsp_valid = 1'b0;
    if (!reset) begin
      pend = 1'b0;
    end else if (pend) begin
      if (pend_cnt <= 1) begin
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = mem_word(pend_addr);
      end else begin
        pend_cnt--;
      end
    end
  end

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  // what: 0 pres_log size >= v, 1 state == v, 2 instr_valid, 3 request valid at addr v
  task automatic wait_for(input int what, input logic [15:0] v, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      case (what)
        0:       hit = (pres_log.size() >= int'(v));
        1:       hit = (state_dbg == v[1:0]);
        2:       hit = instr_valid;
        default: hit = imem.imem_req_valid && (imem.imem_req_addr == v);
      endcase
    end
    if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic redirect(input logic [1:0] sel, input logic ex, input logic [15:0] pc,
                          input logic [15:0] iw, input logic [15:0] tgt);
    redirect_valid = 1'b1; brSel = sel; brEx = ex; br_pc = pc; br_instr = iw; brx_target = tgt;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n0;
    int cnt5;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    instr_ready = 1'b1;
    redirect_valid = 1'b0; brSel = BR_SEQ; brEx = 1'b0;
    br_pc = '0; br_instr = '0; brx_target = '0;

    #1;
    check("rst_req_valid", imem.imem_req_valid, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_pc", PC, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_state", state_dbg, ST_REQ);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 check("release_req_low", imem.imem_req_valid, 1'b0);

    // sequential fetch, 1-cycle memory
    wait_for(0, 16'd3, "seq");
    check("seq_req_n", req_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("seq_req_addr", req_log[i], i);
      check("seq_pres", pres_log[i], {i[15:0], mem_word(i[15:0])});
    end

    // decode backpressure while holding PC 0003
    instr_ready = 1'b0;
    wait_for(2, 16'd0, "bp");
    n0 = req_log.size();
    for (int i = 0; i < 4; i++) begin
      check("bp_pc", PC, 16'h0003);
      check("bp_instr", instr, mem_word(16'h0003));
      check("bp_no_req", imem.imem_req_valid, 1'b0);
      step();
    end
    check("bp_req_count", req_log.size(), n0);
    redirect(BR_SEQ, 1'b0, 16'h0010, 16'hD0FC, 16'h0000);
    step();
    redirect_valid = 1'b0;
    check("seq_sel_no_redirect_valid", instr_valid, 1'b1);
    check("seq_sel_no_redirect_pc", PC, 16'h0003);
    instr_ready = 1'b1;
    pres_log.delete();

    // request stall at 0005
    wait_for(3, 16'h0005, "stall");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", imem.imem_req_addr, 16'h0005);
      check("stall_state", state_dbg, ST_REQ);
    end
    mem_ready = 1'b1;
    wait_for(0, 16'd3, "stall_pres");
    check("stall_pres5", pres_log[2], {16'h0005, mem_word(16'h0005)});
    cnt5 = 0;
    foreach (req_log[i]) if (req_log[i] == 16'h0005) cnt5++;
    check("stall_single_req", cnt5, 1);

    // conditional branch while waiting on a slow response
    mem_lat = 3;
    wait_for(1, {14'd0, ST_WAIT}, "cond_wait");
    redirect(BR_COND, 1'b0, 16'h0010, 16'hD0FC, 16'h0000);
    #1 check("link_addr", link_addr, 16'h0011);
    req_log.delete(); pres_log.delete();
    step();
    redirect_valid = 1'b0;
    check("cond_still_wait", state_dbg, ST_WAIT);
    wait_for(0, 16'd1, "cond_pres");
    check("cond_pres", pres_log[0], {16'h000E, mem_word(16'h000E)});
    check("cond_req_n", req_log.size(), 1);
    check("cond_req_addr", req_log[0], 16'h000E);

    // unconditional branch with wrap, taken from HAVE while held
    mem_lat = 1;
    instr_ready = 1'b0;
    wait_for(2, 16'd0, "b_have");
    redirect(BR_UNCOND, 1'b0, 16'hFFFE, 16'hE005, 16'h0000);
    step();
    redirect_valid = 1'b0;
    check("b_valid_drop", instr_valid, 1'b0);
    check("b_req_addr", imem.imem_req_addr, 16'h0005);
    instr_ready = 1'b1;
    pres_log.delete();
    wait_for(0, 16'd1, "b_pres");
    check("b_pres", pres_log[0], {16'h0005, mem_word(16'h0005)});

    // BX beats brSel=01, taken in REQ while memory stalls
    mem_ready = 1'b0;
    redirect(BR_COND, 1'b1, 16'h0020, 16'hD0FC, 16'h0040);
    step();
    redirect_valid = 1'b0; brEx = 1'b0;
    check("bx_req_valid", imem.imem_req_valid, 1'b1);
    check("bx_req_addr", imem.imem_req_addr, 16'h0040);
    mem_ready = 1'b1;
    pres_log.delete();
    wait_for(0, 16'd1, "bx_pres");
    check("bx_pres", pres_log[0], {16'h0040, mem_word(16'h0040)});

    // redirect in HAVE coinciding with instr_ready
    instr_ready = 1'b0;
    wait_for(2, 16'd0, "have_redir");
    redirect(BR_UNCOND, 1'b0, 16'h0100, 16'hE010, 16'h0000);
    instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("have_redir_valid", instr_valid, 1'b0);
    check("have_redir_addr", imem.imem_req_addr, 16'h0112);
    pres_log.delete();
    wait_for(0, 16'd1, "have_redir_pres");
    check("have_redir_pres", pres_log[0], {16'h0112, mem_word(16'h0112)});

    // asynchronous reset while a response is outstanding
    mem_lat = 3;
    wait_for(1, {14'd0, ST_WAIT}, "rst_wait");
    #2 reset = 1'b0;
    #1;
    check("arst_req_valid", imem.imem_req_valid, 1'b0);
    check("arst_instr_valid", instr_valid, 1'b0);
    check("arst_pc", PC, 16'h0000);
    check("arst_instr", instr, 16'h0000);
    check("arst_state", state_dbg, ST_REQ);
    @(negedge clk);
    reset = 1'b1;
    mem_lat = 1;
    req_log.delete(); pres_log.delete();
    wait_for(0, 16'd1, "arst_restart");
    check("arst_first_req", req_log[0], 16'h0000);
    check("arst_first_pres", pres_log[0], {16'h0000, mem_word(16'h0000)});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
